// File: rtl/kyber_ctrl_pkg.sv
// Shared constants for the Kyber polynomial-op scheduler: command opcodes,
// address-generator select encodings, response status codes and the
// scheduler state encoding.
package kyber_ctrl_pkg;

  localparam int unsigned OP_W     = 2;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned STATUS_W = 2;

  // Host command opcodes
  localparam logic [OP_W-1:0] OP_NTT  = 2'b00;
  localparam logic [OP_W-1:0] OP_INTT = 2'b01;
  localparam logic [OP_W-1:0] OP_PWM  = 2'b10;
  localparam logic [OP_W-1:0] OP_PWA  = 2'b11;

  // Address-generator operation selects
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'b000;
  localparam logic [SEL_W-1:0] SEL_NTT  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_INTT = 3'b100;
  localparam logic [SEL_W-1:0] SEL_PWM  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_PWA  = 3'b110;

  // Response status codes
  localparam logic [STATUS_W-1:0] STATUS_OK      = 2'b00;
  localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [STATUS_W-1:0] STATUS_ABORTED = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_KILL   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  // Map a host opcode onto the generator's select lines
  function automatic logic [SEL_W-1:0] op_to_sel(input logic [OP_W-1:0] op);
    op_to_sel = SEL_NTT;
    case (op)
      OP_NTT:  op_to_sel = SEL_NTT;
      OP_INTT: op_to_sel = SEL_INTT;
      OP_PWM:  op_to_sel = SEL_PWM;
      OP_PWA:  op_to_sel = SEL_PWA;
      default: op_to_sel = SEL_NTT;
    endcase
  endfunction

endpackage

// File: rtl/kyber_op_scheduler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         discard all entries (a push in the same cycle is discarded too)
//   push, wdata   write request and data (ignored when full)
//   pop           remove head entry (ignored when empty)
//   rdata_c       current head entry (combinational read of storage)
//   full, empty   registered occupancy flags
//   empty_nxt_c   occupancy-empty value that will be registered on the next edge
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  // Flush dominates both push and pop
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next occupancy
  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
    end
  end

  assign empty_nxt_c = (count_n == '0);

  // Pointers and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/kyber_op_scheduler.sv
// Command scheduler for the polynomial datapath's address generator.
// Queues NTT/INTT/PWM/PWA commands, launches one at a time on ag_sel with
// bank selects, waits for ag_done, and returns one tagged status per command.
// Owns the run watchdog and the abort path (generator reset via ag_rstn).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_bank, cmd_tag       opcode, {dst, srcB, srcA}, host tag
//   abort                           single-cycle kill / flush request
//   ag_sel, ag_rstn, ag_done        address-generator select, reset, done pulse
//   bank_a, bank_b, bank_d          bank selects of the current op
//   rsp_valid/rsp_ready             response handshake
//   rsp_tag, rsp_status             completed tag and 00 OK / 01 TIMEOUT / 10 ABORTED
//   busy                            not idle or commands pending
module kyber_op_scheduler
  import kyber_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned BANK_W  = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [3*BANK_W-1:0]   cmd_bank,
  input  logic [TAG_W-1:0]      cmd_tag,
  input  logic                  abort,
  output logic [SEL_W-1:0]      ag_sel,
  output logic                  ag_rstn,
  input  logic                  ag_done,
  output logic [BANK_W-1:0]     bank_a,
  output logic [BANK_W-1:0]     bank_b,
  output logic [BANK_W-1:0]     bank_d,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [STATUS_W-1:0]   rsp_status,
  output logic                  busy
);

  localparam int unsigned WORD_W = OP_W + 3 * BANK_W + TAG_W;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned PC_W   = $clog2(GAP + 2);

  state_t              state, state_n;

  // FIFO interface
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_empty_nxt;
  logic                fifo_pop;
  logic [WORD_W-1:0]   fifo_head;

  // Latched command and per-op bookkeeping
  logic [OP_W-1:0]     cur_op, cur_op_n;
  logic [3*BANK_W-1:0] cur_bank, cur_bank_n;
  logic [TAG_W-1:0]    cur_tag, cur_tag_n;
  logic [STATUS_W-1:0] cur_status, cur_status_n;
  logic [WD_W-1:0]     wd, wd_n;
  logic [PC_W-1:0]     cnt, cnt_n;

  // Next values of registered outputs
  logic [SEL_W-1:0]    ag_sel_n;
  logic                ag_rstn_n;
  logic [BANK_W-1:0]   bank_a_n, bank_b_n, bank_d_n;
  logic                rsp_valid_n;
  logic [TAG_W-1:0]    rsp_tag_n;
  logic [STATUS_W-1:0] rsp_status_n;
  logic                busy_n;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (abort),
    .push        (cmd_valid && cmd_ready),
    .wdata       ({cmd_op, cmd_bank, cmd_tag}),
    .pop         (fifo_pop),
    .rdata_c     (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Driven straight from the FIFO's registered full flag
  assign cmd_ready = ~fifo_full;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    fifo_pop     = 1'b0;
    cur_op_n     = cur_op;
    cur_bank_n   = cur_bank;
    cur_tag_n    = cur_tag;
    cur_status_n = cur_status;
    wd_n         = wd;
    cnt_n        = cnt;
    ag_sel_n     = ag_sel;
    ag_rstn_n    = ag_rstn;
    bank_a_n     = bank_a;
    bank_b_n     = bank_b;
    bank_d_n     = bank_d;
    rsp_valid_n  = rsp_valid;
    rsp_tag_n    = rsp_tag;
    rsp_status_n = rsp_status;

    case (state)
      S_IDLE: begin
        // An abort here flushes the queue, so nothing is launched
        if (!fifo_empty && !rsp_valid && !abort) begin
          fifo_pop = 1'b1;
          {cur_op_n, cur_bank_n, cur_tag_n} = fifo_head;
          state_n = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (abort) begin
          cur_status_n = STATUS_ABORTED;
          ag_sel_n     = SEL_IDLE;
          ag_rstn_n    = 1'b0;
          cnt_n        = '0;
          state_n      = S_KILL;
        end else begin
          ag_sel_n = op_to_sel(cur_op);
          bank_a_n = cur_bank[BANK_W-1:0];
          bank_b_n = cur_bank[2*BANK_W-1:BANK_W];
          bank_d_n = cur_bank[3*BANK_W-1:2*BANK_W];
          wd_n     = '0;
          state_n  = S_RUN;
        end
      end

      S_RUN: begin
        // done beats both abort and the watchdog in the same cycle
        if (ag_done) begin
          ag_sel_n     = SEL_IDLE;
          cur_status_n = STATUS_OK;
          cnt_n        = '0;
          state_n      = S_GAP;
        end else if (abort) begin
          ag_sel_n     = SEL_IDLE;
          ag_rstn_n    = 1'b0;
          cur_status_n = STATUS_ABORTED;
          cnt_n        = '0;
          state_n      = S_KILL;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          ag_sel_n     = SEL_IDLE;
          ag_rstn_n    = 1'b0;
          cur_status_n = STATUS_TIMEOUT;
          cnt_n        = '0;
          state_n      = S_KILL;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end

      S_GAP: begin
        ag_sel_n = SEL_IDLE;
        if (cnt == PC_W'(GAP - 1)) begin
          rsp_valid_n  = 1'b1;
          rsp_tag_n    = cur_tag;
          rsp_status_n = cur_status;
          state_n      = S_RESP;
        end else begin
          cnt_n = cnt + PC_W'(1);
        end
      end

      S_KILL: begin
        // Generator reset held low for exactly two cycles
        ag_sel_n = SEL_IDLE;
        if (cnt == PC_W'(1)) begin
          ag_rstn_n    = 1'b1;
          rsp_valid_n  = 1'b1;
          rsp_tag_n    = cur_tag;
          rsp_status_n = cur_status;
          state_n      = S_RESP;
        end else begin
          ag_rstn_n = 1'b0;
          cnt_n     = cnt + PC_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE) || !fifo_empty_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_op     <= '0;
      cur_bank   <= '0;
      cur_tag    <= '0;
      cur_status <= STATUS_OK;
      wd         <= '0;
      cnt        <= '0;
      ag_sel     <= SEL_IDLE;
      ag_rstn    <= 1'b1;
      bank_a     <= '0;
      bank_b     <= '0;
      bank_d     <= '0;
      rsp_valid  <= 1'b0;
      rsp_tag    <= '0;
      rsp_status <= STATUS_OK;
      busy       <= 1'b0;
    end else begin
      cur_op     <= cur_op_n;
      cur_bank   <= cur_bank_n;
      cur_tag    <= cur_tag_n;
      cur_status <= cur_status_n;
      wd         <= wd_n;
      cnt        <= cnt_n;
      ag_sel     <= ag_sel_n;
      ag_rstn    <= ag_rstn_n;
      bank_a     <= bank_a_n;
      bank_b     <= bank_b_n;
      bank_d     <= bank_d_n;
      rsp_valid  <= rsp_valid_n;
      rsp_tag    <= rsp_tag_n;
      rsp_status <= rsp_status_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_kyber_op_scheduler.sv
// Self-checking bench for kyber_op_scheduler: a table of single-command
// vectors plus directed sequences for back-to-back, full FIFO, timeout,
// abort and asynchronous reset.
module tb_kyber_op_scheduler;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned BANK_W  = 2;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned GAP     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = '0;
  logic [3*BANK_W-1:0] cmd_bank = '0;
  logic [TAG_W-1:0]    cmd_tag = '0;
  logic                abort = 1'b0;
  logic [2:0]          ag_sel;
  logic                ag_rstn;
  logic                ag_done = 1'b0;
  logic [BANK_W-1:0]   bank_a, bank_b, bank_d;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [TAG_W-1:0]    rsp_tag;
  logic [1:0]          rsp_status;
  logic                busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]          op;
    logic [3*BANK_W-1:0] bank;
    logic [TAG_W-1:0]    tag;
    int                  delay;
    logic [2:0]          sel;
  } vec_t;

  vec_t vecs[4];

  kyber_op_scheduler #(
    .DEPTH   (DEPTH),
    .BANK_W  (BANK_W),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_bank   (cmd_bank),
    .cmd_tag    (cmd_tag),
    .abort      (abort),
    .ag_sel     (ag_sel),
    .ag_rstn    (ag_rstn),
    .ag_done    (ag_done),
    .bank_a     (bank_a),
    .bank_b     (bank_b),
    .bank_d     (bank_d),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_tag    (rsp_tag),
    .rsp_status (rsp_status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL sim_timeout: simulation did not finish, got stuck, required completion");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3*BANK_W-1:0] bank,
                      input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_bank  = bank;
    cmd_tag   = tag;
    step();
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for a nonzero select; an expired bound shows up as n == 64
  task automatic wait_launch(output int n);
    n = 0;
    while (ag_sel == 3'b000 && n < 64) begin
      step();
      n++;
    end
    check("launch_seen", 32'(ag_sel != 3'b000), 1);
  endtask

  task automatic run_one(input vec_t v);
    int   n;
    logic held;
    push(v.op, v.bank, v.tag);
    check("busy_after_push", 32'(busy), 1);
    wait_launch(n);
    check("launch_latency", 32'(n), 2);
    check("sel", 32'(ag_sel), 32'(v.sel));
    check("bank_a", 32'(bank_a), 32'(v.bank[BANK_W-1:0]));
    check("bank_b", 32'(bank_b), 32'(v.bank[2*BANK_W-1:BANK_W]));
    check("bank_d", 32'(bank_d), 32'(v.bank[3*BANK_W-1:2*BANK_W]));
    held = 1'b1;
    for (int i = 0; i < v.delay - 1; i++) begin
      step();
      if (ag_sel !== v.sel || ag_rstn !== 1'b1 || rsp_valid !== 1'b0) held = 1'b0;
    end
    check("sel_held_in_run", 32'(held), 1);
    ag_done = 1'b1;
    step();
    ag_done = 1'b0;
    check("sel_off_on_done", 32'(ag_sel), 0);
    step();
    check("gap1_no_rsp", 32'(rsp_valid), 0);
    check("gap1_sel", 32'(ag_sel), 0);
    step();
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_tag", 32'(rsp_tag), 32'(v.tag));
    check("rsp_status", 32'(rsp_status), 0);
    check("banks_hold_a", 32'(bank_a), 32'(v.bank[BANK_W-1:0]));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_dropped", 32'(rsp_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int   n;
    logic ok;

    vecs[0] = '{op: 2'b00, bank: 6'b10_01_00, tag: 4'd5,  delay: 300, sel: 3'b001};
    vecs[1] = '{op: 2'b01, bank: 6'b11_10_01, tag: 4'd9,  delay: 20,  sel: 3'b100};
    vecs[2] = '{op: 2'b10, bank: 6'b00_11_10, tag: 4'd12, delay: 5,   sel: 3'b010};
    vecs[3] = '{op: 2'b11, bank: 6'b01_00_11, tag: 4'd15, delay: 1,   sel: 3'b110};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ag_sel", 32'(ag_sel), 0);
    check("rst_ag_rstn", 32'(ag_rstn), 1);
    check("rst_banks", 32'({bank_a, bank_b, bank_d}), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_tag", 32'(rsp_tag), 0);
    check("rst_rsp_status", 32'(rsp_status), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ag_done while idle must be ignored
    ag_done = 1'b1;
    step();
    ag_done = 1'b0;
    step();
    check("done_idle_sel", 32'(ag_sel), 0);
    check("done_idle_busy", 32'(busy), 0);
    check("done_idle_rsp", 32'(rsp_valid), 0);

    // Table of single commands
    for (int k = 0; k < 4; k++) run_one(vecs[k]);

    // Back-to-back PWA then INTT with the host always ready
    rsp_ready = 1'b1;
    push(2'b11, 6'b00_01_10, 4'd3);
    push(2'b01, 6'b10_00_01, 4'd4);
    wait_launch(n);
    check("b2b_sel1", 32'(ag_sel), 32'(3'b110));
    repeat (9) step();
    ag_done = 1'b1;
    step();
    ag_done = 1'b0;
    step();
    step();
    check("b2b_rsp1_valid", 32'(rsp_valid), 1);
    check("b2b_rsp1_tag", 32'(rsp_tag), 3);
    step();
    check("b2b_rsp1_dropped", 32'(rsp_valid), 0);
    step();
    check("b2b_launch_cycle_sel", 32'(ag_sel), 0);
    step();
    check("b2b_sel2", 32'(ag_sel), 32'(3'b100));
    check("b2b_bank_a2", 32'(bank_a), 1);
    repeat (2) step();
    ag_done = 1'b1;
    step();
    ag_done = 1'b0;
    step();
    step();
    check("b2b_rsp2_valid", 32'(rsp_valid), 1);
    check("b2b_rsp2_tag", 32'(rsp_tag), 4);
    step();
    rsp_ready = 1'b0;
    check("b2b_busy_end", 32'(busy), 0);

    // Fill the FIFO while one op runs; hold the response; abort in RESP
    push(2'b00, 6'b00_00_01, 4'd1);
    wait_launch(n);
    push(2'b10, 6'b00_00_10, 4'd2);
    push(2'b11, 6'b00_00_11, 4'd3);
    push(2'b01, 6'b00_01_00, 4'd4);
    check("fifo_3_ready", 32'(cmd_ready), 1);
    push(2'b00, 6'b00_01_01, 4'd5);
    check("fifo_4_full", 32'(cmd_ready), 0);
    ag_done = 1'b1;
    step();
    ag_done = 1'b0;
    step();
    step();
    check("full_rsp_tag", 32'(rsp_tag), 1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ag_sel !== 3'b000 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) ok = 1'b0;
    end
    check("no_launch_while_rsp_pending", 32'(ok), 1);
    rsp_ready = 1'b1;
    abort = 1'b1;
    step();
    rsp_ready = 1'b0;
    abort = 1'b0;
    check("resp_abort_rsp_dropped", 32'(rsp_valid), 0);
    check("resp_abort_busy", 32'(busy), 0);
    check("resp_abort_ready", 32'(cmd_ready), 1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ag_sel !== 3'b000 || busy !== 1'b0) ok = 1'b0;
    end
    check("resp_abort_flushed", 32'(ok), 1);

    // Abort mid-PWM with two commands queued
    push(2'b10, 6'b01_10_11, 4'd7);
    wait_launch(n);
    check("pwm_sel", 32'(ag_sel), 32'(3'b010));
    push(2'b00, 6'b00_00_00, 4'd8);
    push(2'b01, 6'b00_00_00, 4'd9);
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_kill1_rstn", 32'(ag_rstn), 0);
    check("abort_kill1_sel", 32'(ag_sel), 0);
    check("abort_flush_ready", 32'(cmd_ready), 1);
    step();
    check("abort_kill2_rstn", 32'(ag_rstn), 0);
    check("abort_kill2_rsp", 32'(rsp_valid), 0);
    step();
    check("abort_rstn_back", 32'(ag_rstn), 1);
    check("abort_rsp_valid", 32'(rsp_valid), 1);
    check("abort_rsp_tag", 32'(rsp_tag), 7);
    check("abort_rsp_status", 32'(rsp_status), 2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("abort_busy_after", 32'(busy), 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ag_sel !== 3'b000 || rsp_valid !== 1'b0) ok = 1'b0;
    end
    check("abort_no_more_rsp", 32'(ok), 1);

    // ag_done and abort in the same RUN cycle: done wins, queue still flushed
    push(2'b00, 6'b00_00_01, 4'd10);
    wait_launch(n);
    push(2'b01, 6'b00_00_00, 4'd11);
    repeat (3) step();
    ag_done = 1'b1;
    abort = 1'b1;
    step();
    ag_done = 1'b0;
    abort = 1'b0;
    check("tie_rstn_high", 32'(ag_rstn), 1);
    check("tie_sel_off", 32'(ag_sel), 0);
    step();
    step();
    check("tie_rsp_valid", 32'(rsp_valid), 1);
    check("tie_rsp_tag", 32'(rsp_tag), 10);
    check("tie_rsp_status", 32'(rsp_status), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("tie_busy_after", 32'(busy), 0);

    // Watchdog: no ag_done
    push(2'b01, 6'b00_00_00, 4'd13);
    wait_launch(n);
    ok = 1'b1;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      step();
      if (ag_rstn !== 1'b1 || ag_sel !== 3'b100) ok = 1'b0;
    end
    check("wd_run_1023_cycles", 32'(ok), 1);
    step();
    check("wd_kill1_rstn", 32'(ag_rstn), 0);
    check("wd_kill1_sel", 32'(ag_sel), 0);
    step();
    check("wd_kill2_rstn", 32'(ag_rstn), 0);
    step();
    check("wd_rstn_back", 32'(ag_rstn), 1);
    check("wd_rsp_valid", 32'(rsp_valid), 1);
    check("wd_rsp_tag", 32'(rsp_tag), 13);
    check("wd_rsp_status", 32'(rsp_status), 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Asynchronous reset between edges in the middle of RUN
    push(2'b11, 6'b11_11_11, 4'd14);
    wait_launch(n);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel", 32'(ag_sel), 0);
    check("arst_banks", 32'({bank_a, bank_b, bank_d}), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(cmd_ready), 1);
    check("arst_rstn", 32'(ag_rstn), 1);
    check("arst_rsp_tag", 32'(rsp_tag), 0);
    check("arst_rsp_status", 32'(rsp_status), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_one(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
